// File: rtl/mem_sram_controller_pkg.sv
// Shared types and helpers for the MEM-stage SRAM controller.
package mem_ctrl_pkg;

    // Access sequencer states: one idle, two half-word phases, one completion cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

    // Byte address -> SRAM 32-bit word index. The subtraction wraps modulo 2^32,
    // so addresses below the base alias high in the SRAM; no range check is done.
    function automatic logic [31:0] sram_word_addr(input logic [31:0] address,
                                                   input logic [31:0] base = DEFAULT_BASE_ADDR);
        return (address - base) >> 2;
    endfunction

    // Counter width for a 0..n-1 phase count, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_sram_controller_if.sv
// Pipeline-side and SRAM-side signals of the MEM-stage SRAM controller.
// slave = controller view, master = pipeline plus SRAM device view.
interface mem_sram_if #(
    parameter int SRAM_AW = 18
);
    logic               wr_en;
    logic               rd_en;
    logic [31:0]        address;
    logic [31:0]        write_data;
    logic [31:0]        read_data;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_we_n;

    modport slave (
        input  wr_en, rd_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );

    modport master (
        output wr_en, rd_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n
    );
endinterface

// File: rtl/mem_sram_controller_phase_counter.sv
// Counts the cycles a half-word access is held on the SRAM bus.
module sram_phase_counter
    import mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int CW          = cnt_width(WAIT_CYCLES)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_enable,
    output logic [CW-1:0] o_cnt,
    output logic          o_last
);
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    // Phase counter: clear has priority so a finished phase restarts at zero.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)        r_cnt <= '0;
        else if (i_clear)  r_cnt <= '0;
        else if (i_enable) r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == LAST_CNT);
endmodule

// File: rtl/mem_sram_controller.sv
// MEM-stage controller: splits 32-bit loads/stores into two timed 16-bit
// accesses on an asynchronous SRAM and freezes the pipeline meanwhile.
module mem_sram_controller
    import mem_ctrl_pkg::*;
#(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          SRAM_AW     = 18
) (
    input  logic      i_clk,
    input  logic      i_rst,
    mem_sram_if.slave bus
);
    localparam int CW = cnt_width(WAIT_CYCLES);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_op_write;
    logic [SRAM_AW-2:0] r_word;
    logic [31:0]        r_wdata;
    logic [31:0]        r_read_data;

    logic               w_req;
    logic [SRAM_AW-2:0] w_word;
    logic [CW-1:0]      w_cnt;
    logic               w_last;
    logic               w_cnt_en;
    logic               w_cnt_clear;
    logic [SRAM_AW-1:0] w_sram_addr;
    logic [15:0]        w_dq_out;
    logic               w_dq_oe;
    logic               w_we_n;

    assign w_req  = bus.wr_en | bus.rd_en;
    assign w_word = (SRAM_AW-1)'(sram_word_addr(bus.address, BASE_ADDR));

    // The counter runs only during the half-word phases and restarts after each one.
    assign w_cnt_en    = (r_state == LOW) || (r_state == HIGH);
    assign w_cnt_clear = !w_cnt_en || w_last;

    sram_phase_counter #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .CW          (CW)
    ) u_phase_counter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_cnt_clear),
        .i_enable (w_cnt_en),
        .o_cnt    (w_cnt),
        .o_last   (w_last)
    );

    // State register; reset aborts any access immediately, so a write may be torn.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next-state logic: an accepted access always runs through DONE, even if flushed.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_req)  w_next_state = LOW;
            LOW:     if (w_last) w_next_state = HIGH;
            HIGH:    if (w_last) w_next_state = DONE;
            DONE:                w_next_state = IDLE;
            default:             w_next_state = IDLE;
        endcase
    end

    // Latch the request in IDLE; a store wins over a simultaneous load.
    // NOTE: these holding registers are reset only for deterministic start-up.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_op_write <= 1'b0;
            r_word     <= '0;
            r_wdata    <= '0;
        end else if ((r_state == IDLE) && w_req) begin
            r_op_write <= bus.wr_en;
            r_word     <= w_word;
            r_wdata    <= bus.write_data;
        end
    end

    // Capture each load half on the last cycle of its phase; stores leave it alone.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_read_data <= '0;
        end else if (!r_op_write && w_last) begin
            if (r_state == LOW)  r_read_data[15:0]  <= bus.sram_dq_in;
            if (r_state == HIGH) r_read_data[31:16] <= bus.sram_dq_in;
        end
    end

    // SRAM bus drive: only the half-word phases touch the bus; strobes idle high.
    always_comb begin
        w_sram_addr = '0;
        w_dq_out    = '0;
        w_dq_oe     = 1'b0;
        w_we_n      = 1'b1;
        if (r_state == LOW || r_state == HIGH) begin
            w_sram_addr = {r_word, (r_state == HIGH)};
            if (r_op_write) begin
                w_we_n   = 1'b0;
                w_dq_oe  = 1'b1;
                w_dq_out = (r_state == HIGH) ? r_wdata[31:16] : r_wdata[15:0];
            end
        end
    end

    assign bus.sram_addr   = w_sram_addr;
    assign bus.sram_dq_out = w_dq_out;
    assign bus.sram_dq_oe  = w_dq_oe;
    assign bus.sram_we_n   = w_we_n;
    assign bus.read_data   = r_read_data;
    assign bus.ready       = !w_req || (r_state == DONE);
endmodule
